reg_context_sequencer: RTL and testbench

Sequencer that moves general-purpose register contents to and from data memory for context save/restore (interrupt entry/exit, task switch). It drives the GP register file's select/enable/data ports from the master side and issues single-word memory transactions over a req/ack handshake. Control logic starts it with one `start` pulse and waits for a one-cycle `done`.

---
 rtl/cpu16_defs.sv | 19 +
 rtl/reg_context_sequencer.sv | 166 ++++++++++++++++
 tb/tb_reg_context_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu16_defs.sv
// Shared widths and sequencer state encodings for the cpu16 register/memory path.
package cpu16_defs;

    localparam int DATA_W      = 16;
    localparam int REG_SEL_W   = 4;
    localparam int NUM_GP_REGS = 16;
    localparam int ADDR_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_SAVE_RD  = 3'd2,
        ST_SAVE_REQ = 3'd3,
        ST_REST_REQ = 3'd4,
        ST_REST_WR  = 3'd5,
        ST_DONE     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/reg_context_sequencer.sv
// Context save/restore sequencer: walks the GP register mask and moves each selected
// register to/from consecutive memory words over a single-word req/ack handshake.
module reg_context_sequencer
    import cpu16_defs::*;
#(
    parameter int DATA_W    = cpu16_defs::DATA_W,
    parameter int REG_SEL_W = cpu16_defs::REG_SEL_W,
    parameter int ADDR_W    = cpu16_defs::ADDR_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_dir,
    input  logic [ADDR_W-1:0]      i_base_addr,
    input  logic [NUM_GP_REGS-1:0] i_reg_mask,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [REG_SEL_W-1:0]   o_gp_rd_sel,
    output logic                   o_gp_out_en,
    input  logic [DATA_W-1:0]      i_gp_rd_data,
    output logic [REG_SEL_W-1:0]   o_gp_wr_sel,
    output logic                   o_gp_wr_en,
    output logic [DATA_W-1:0]      o_gp_wr_data,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]      o_mem_wdata,
    input  logic                   i_mem_ack,
    input  logic [DATA_W-1:0]      i_mem_rdata
);

    seq_state_t             r_state;
    logic [REG_SEL_W-1:0]   r_idx;
    logic [ADDR_W-1:0]      r_cnt;
    logic [DATA_W-1:0]      r_hold;
    logic                   r_dir;
    logic [ADDR_W-1:0]      r_base;
    logic [NUM_GP_REGS-1:0] r_mask;

    logic                   r_busy;
    logic                   r_done;
    logic [REG_SEL_W-1:0]   r_gp_rd_sel;
    logic                   r_gp_out_en;
    logic [REG_SEL_W-1:0]   r_gp_wr_sel;
    logic                   r_gp_wr_en;
    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;

    logic                   w_last;
    logic [ADDR_W-1:0]      w_addr;

    assign w_last = (r_idx == REG_SEL_W'(NUM_GP_REGS - 1));
    assign w_addr = r_base + r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_dir       <= 1'b0;
            r_base      <= '0;
            r_mask      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gp_rd_sel <= '0;
            r_gp_out_en <= 1'b0;
            r_gp_wr_sel <= '0;
            r_gp_wr_en  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_gp_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_dir   <= i_dir;
                        r_base  <= i_base_addr;
                        r_mask  <= i_reg_mask;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_mask[r_idx]) begin
                        if (r_dir) begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_addr;
                            r_state    <= ST_REST_REQ;
                        end else begin
                            r_gp_rd_sel <= r_idx;
                            r_gp_out_en <= 1'b1;
                            r_state     <= ST_SAVE_RD;
                        end
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_done  <= w_last;
                        r_state <= w_last ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SAVE_RD: begin
                    r_hold      <= i_gp_rd_data;
                    r_gp_out_en <= 1'b0;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_addr;
                    r_state     <= ST_SAVE_REQ;
                end
                ST_SAVE_REQ: begin
                    // Address/data/we stay frozen in their flops until the ack edge.
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_cnt     <= r_cnt + 1'b1;
                        r_idx     <= r_idx + 1'b1;
                        r_done    <= w_last;
                        r_state   <= w_last ? ST_DONE : ST_SCAN;
                    end
                end
                ST_REST_REQ: begin
                    if (i_mem_ack) begin
                        r_hold      <= i_mem_rdata;
                        r_mem_req   <= 1'b0;
                        r_gp_wr_sel <= r_idx;
                        r_gp_wr_en  <= 1'b1;
                        r_state     <= ST_REST_WR;
                    end
                end
                ST_REST_WR: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_idx   <= r_idx + 1'b1;
                    r_done  <= w_last;
                    r_state <= w_last ? ST_DONE : ST_SCAN;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_gp_rd_sel  = r_gp_rd_sel;
    assign o_gp_out_en  = r_gp_out_en;
    assign o_gp_wr_sel  = r_gp_wr_sel;
    assign o_gp_wr_en   = r_gp_wr_en;
    assign o_gp_wr_data = r_hold;
    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_hold;

endmodule

// File: tb/tb_reg_context_sequencer.sv
// Directed bench for reg_context_sequencer with a register-file model and a memory
// responder whose ack latency is programmable per scenario.
module tb_reg_context_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] base = '0;
    logic [15:0] mask = '0;
    logic        busy, done;
    logic [3:0]  gp_rd_sel, gp_wr_sel;
    logic        gp_out_en, gp_wr_en;
    logic [15:0] gp_rd_data, gp_wr_data;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    reg_context_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_dir(dir),
        .i_base_addr(base), .i_reg_mask(mask),
        .o_busy(busy), .o_done(done),
        .o_gp_rd_sel(gp_rd_sel), .o_gp_out_en(gp_out_en), .i_gp_rd_data(gp_rd_data),
        .o_gp_wr_sel(gp_wr_sel), .o_gp_wr_en(gp_wr_en), .o_gp_wr_data(gp_wr_data),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    // Models: register file, memory, and traffic monitors (single writer each).
    logic [15:0] rf [16];
    logic [15:0] mem [65536];
    logic        rf_ld = 1'b0, mem_ld = 1'b0;
    logic [3:0]  rf_ld_sel = '0;
    logic [15:0] rf_ld_data = '0, mem_ld_addr = '0, mem_ld_data = '0;
    int          ack_delay = 0;
    int          wcnt = 0;
    int          busy_cyc = 0, done_cnt = 0, req_cyc = 0, mwr_cnt = 0, gwr_cnt = 0, stab_err = 0;
    logic        pend = 1'b0, pwe = 1'b0;
    logic [15:0] paddr = '0, pwdata = '0;

    assign mem_ack    = mem_req && (wcnt >= ack_delay);
    assign mem_rdata  = mem[mem_addr];
    assign gp_rd_data = gp_out_en ? rf[gp_rd_sel] : 16'h0;

    always @(posedge clk) begin
        if (mem_ld) mem[mem_ld_addr] <= mem_ld_data;
        else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
        if (rf_ld) rf[rf_ld_sel] <= rf_ld_data;
        else if (gp_wr_en) rf[gp_wr_sel] <= gp_wr_data;
        wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_req) req_cyc <= req_cyc + 1;
        if (mem_req && mem_ack && mem_we) mwr_cnt <= mwr_cnt + 1;
        if (gp_wr_en) gwr_cnt <= gwr_cnt + 1;
        if (pend && mem_req && (mem_addr != paddr || mem_wdata != pwdata || mem_we != pwe))
            stab_err <= stab_err + 1;
        pend   <= mem_req && !mem_ack;
        paddr  <= mem_addr;
        pwdata <= mem_wdata;
        pwe    <= mem_we;
    end

    int errors = 0;
    int checks = 0;

    task automatic rf_set(input logic [3:0] i, input logic [15:0] v);
        @(negedge clk); rf_ld = 1'b1; rf_ld_sel = i; rf_ld_data = v;
        @(negedge clk); rf_ld = 1'b0;
    endtask

    task automatic mem_set(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk); mem_ld = 1'b1; mem_ld_addr = a; mem_ld_data = v;
        @(negedge clk); mem_ld = 1'b0;
    endtask

    // Returns n = cycle (1 = first cycle after the accepting edge) in which done is seen.
    task automatic run_op(input logic d, input logic [15:0] b, input logic [15:0] m, output int n);
        @(negedge clk); dir = d; base = b; mask = m; start = 1'b1;
        @(negedge clk); start = 1'b0; n = 1;
        while (!done && n < 400) begin @(negedge clk); n++; end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, gp_rd_sel, gp_out_en, gp_wr_sel, gp_wr_en, gp_wr_data,
             mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero output vector, expected all 0");
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_save_full;
        int n, b0, d0, w0;
        for (int i = 0; i < 16; i++) rf_set(4'(i), 16'hA000 + 16'(i));
        ack_delay = 0;
        b0 = busy_cyc; d0 = done_cnt; w0 = mwr_cnt;
        run_op(1'b0, 16'h0100, 16'hFFFF, n);
        checks++;
        if (n !== 48 + 1) begin errors++; $display("FAIL save_full_done_cycle: got %0d expected 49", n); end
        checks++;
        if (busy_cyc - b0 !== 49) begin errors++; $display("FAIL save_full_busy: got %0d expected 49", busy_cyc - b0); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL save_full_done_pulses: got %0d expected 1", done_cnt - d0); end
        checks++;
        if (mwr_cnt - w0 !== 16) begin errors++; $display("FAIL save_full_writes: got %0d expected 16", mwr_cnt - w0); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[16'h0100 + 16'(i)] !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL save_full_mem[%0d]: got %h expected %h", i, mem[16'h0100 + 16'(i)], 16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_restore_wrap;
        int n, g0, w0;
        mem_set(16'hFFFE, 16'h1111);
        mem_set(16'hFFFF, 16'h2222);
        mem_set(16'h0000, 16'h3333);
        g0 = gwr_cnt; w0 = mwr_cnt;
        run_op(1'b1, 16'hFFFE, 16'h8005, n);
        checks++;
        if (n !== 23) begin errors++; $display("FAIL restore_done_cycle: got %0d expected 23", n); end
        checks++;
        if (rf[0] !== 16'h1111) begin errors++; $display("FAIL restore_r0: got %h expected 1111", rf[0]); end
        checks++;
        if (rf[2] !== 16'h2222) begin errors++; $display("FAIL restore_r2: got %h expected 2222", rf[2]); end
        checks++;
        if (rf[15] !== 16'h3333) begin errors++; $display("FAIL restore_r15_wrap: got %h expected 3333", rf[15]); end
        checks++;
        if (rf[1] !== 16'hA001 || rf[14] !== 16'hA00E) begin
            errors++; $display("FAIL restore_unchanged: got r1=%h r14=%h expected A001 A00E", rf[1], rf[14]);
        end
        checks++;
        if (gwr_cnt - g0 !== 3 || mwr_cnt - w0 !== 0) begin
            errors++; $display("FAIL restore_traffic: got gpwr=%0d memwr=%0d expected 3 0", gwr_cnt - g0, mwr_cnt - w0);
        end
    endtask

    task automatic test_delayed_ack;
        int n, s0, w0, r0;
        ack_delay = 3;
        s0 = stab_err; w0 = mwr_cnt; r0 = req_cyc;
        run_op(1'b0, 16'h0400, 16'h0003, n);
        ack_delay = 0;
        checks++;
        if (stab_err - s0 !== 0) begin errors++; $display("FAIL delayed_stability: got %0d unstable cycles expected 0", stab_err - s0); end
        checks++;
        if (mwr_cnt - w0 !== 2) begin errors++; $display("FAIL delayed_writes: got %0d expected 2", mwr_cnt - w0); end
        checks++;
        if (req_cyc - r0 !== 8) begin errors++; $display("FAIL delayed_req_cycles: got %0d expected 8", req_cyc - r0); end
        checks++;
        if (n !== 27) begin errors++; $display("FAIL delayed_done_cycle: got %0d expected 27", n); end
        checks++;
        if (mem[16'h0400] !== 16'h1111 || mem[16'h0401] !== 16'hA001) begin
            errors++; $display("FAIL delayed_mem: got %h %h expected 1111 A001", mem[16'h0400], mem[16'h0401]);
        end
    endtask

    task automatic test_empty_mask;
        int n, r0, g0, b0;
        r0 = req_cyc; g0 = gwr_cnt; b0 = busy_cyc;
        run_op(1'b1, 16'h0500, 16'h0000, n);
        checks++;
        if (n !== 17) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 17", n); end
        checks++;
        if (req_cyc - r0 !== 0 || gwr_cnt - g0 !== 0) begin
            errors++; $display("FAIL empty_traffic: got req=%0d gpwr=%0d expected 0 0", req_cyc - r0, gwr_cnt - g0);
        end
        checks++;
        if (busy_cyc - b0 !== 17) begin errors++; $display("FAIL empty_busy: got %0d expected 17", busy_cyc - b0); end
    endtask

    task automatic test_start_while_busy;
        int n, w0, g0, d0;
        mem_set(16'h0300, 16'hDEAD);
        w0 = mwr_cnt; g0 = gwr_cnt; d0 = done_cnt;
        @(negedge clk); dir = 1'b0; base = 16'h0200; mask = 16'h0005; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        dir = 1'b1; base = 16'h0300; mask = 16'hFFFF; start = 1'b1;
        @(negedge clk); start = 1'b0; n = 6;
        while (!done && n < 400) begin @(negedge clk); n++; end
        // a start pulse in the DONE cycle must also be dropped
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n !== 21) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 21", n); end
        checks++;
        if (mem[16'h0200] !== 16'h1111 || mem[16'h0201] !== 16'h2222) begin
            errors++; $display("FAIL busy_start_mem: got %h %h expected 1111 2222", mem[16'h0200], mem[16'h0201]);
        end
        checks++;
        if (mem[16'h0300] !== 16'hDEAD) begin errors++; $display("FAIL busy_start_untouched: got %h expected DEAD", mem[16'h0300]); end
        checks++;
        if (mwr_cnt - w0 !== 2 || gwr_cnt - g0 !== 0 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL busy_start_traffic: got memwr=%0d gpwr=%0d done=%0d expected 2 0 1",
                               mwr_cnt - w0, gwr_cnt - g0, done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_rst_mid_op;
        int n, k, g0;
        ack_delay = 10;
        g0 = gwr_cnt;
        @(negedge clk); dir = 1'b1; base = 16'h0010; mask = 16'h0001; start = 1'b1;
        @(negedge clk); start = 1'b0; k = 0;
        while (!mem_req && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_reach_req: got mem_req=%b expected 1", mem_req); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, gp_out_en, gp_wr_en, mem_req, mem_we, mem_addr} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got busy=%b req=%b we=%b addr=%h expected 0", busy, mem_req, mem_we, mem_addr);
        end
        @(negedge clk); rst = 1'b0; ack_delay = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (gwr_cnt - g0 !== 0 || rf[0] !== 16'h1111) begin
            errors++; $display("FAIL rst_mid_no_write: got gpwr=%0d r0=%h expected 0 1111", gwr_cnt - g0, rf[0]);
        end
        run_op(1'b0, 16'h0020, 16'h0001, n);
        checks++;
        if (n !== 19) begin errors++; $display("FAIL rst_restart_done_cycle: got %0d expected 19", n); end
        checks++;
        if (mem[16'h0020] !== 16'h1111) begin errors++; $display("FAIL rst_restart_mem: got %h expected 1111", mem[16'h0020]); end
    endtask

    initial begin
        test_reset();
        test_save_full();
        test_restore_wrap();
        test_delayed_ack();
        test_empty_mask();
        test_start_while_busy();
        test_rst_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
